// File: rtl/rbt_phv_pkg.sv
// Shared PHV lane map, tag bits and IPv6 constants for the header deparsers.
package rbt_phv_pkg;

    // PHV word lane indices
    localparam int unsigned PROTO_NO        = 0;
    localparam int unsigned DST_IP_NO       = 1;
    localparam int unsigned SRC_IPV6_NO     = 5;
    // PHV byte lane holding the remaining-payload offset
    localparam int unsigned SEATL_OFFSET_NO = 6;

    // Tag bits inside PHV word PROTO_NO
    localparam int unsigned TAG_IPV6 = 4;
    localparam int unsigned TAG_IDP  = 5;

    localparam logic [7:0]  NEXT_HDR_IDP   = 8'h92;
    localparam logic [7:0]  IPV6_HDR_BYTES = 8'd40;
    localparam int unsigned IPV6_HDR_BITS  = 320;

    // a - b, clamped at zero
    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/rbt_hdr_pipe_stage.sv
// One valid/ready register slice; payload only changes on an accepted transfer.
module rbt_hdr_pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Load on accept, otherwise empty when the consumer takes the item
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slice registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/rbt_s_ipv6_deparser.sv
// Two-stage deparser: prepends an IPv6 header to tagged items, passes others through.
module rbt_s_ipv6_deparser
    import rbt_phv_pkg::*;
#(
    parameter int unsigned HEADER_WIDTH     = 2048,
    parameter int unsigned PHV_WIDTH        = 408,
    parameter int unsigned PHV_B_NUM        = 7,
    parameter int unsigned PHV_H_NUM        = 2,
    parameter int unsigned PHV_W_NUM        = 10,
    parameter logic [7:0]  HOP_LIMIT        = 8'd64,
    parameter logic [7:0]  NEXT_HDR_DEFAULT = 8'h11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_proto_hdr_valid,
    output logic                    in_proto_hdr_ready,
    input  logic [15:0]             in_proto_hdr_length,
    input  logic [HEADER_WIDTH-1:0] in_proto_hdr_data,
    input  logic [PHV_WIDTH-1:0]    in_proto_hdr_phv,
    output logic                    out_proto_hdr_valid,
    input  logic                    out_proto_hdr_ready,
    output logic [HEADER_WIDTH-1:0] out_proto_hdr_data,
    output logic [PHV_WIDTH-1:0]    out_proto_hdr_phv,
    output logic [15:0]             out_proto_hdr_length,
    output logic [15:0]             drop_count,
    output logic [15:0]             tx_count
);

    localparam int unsigned BUS_W     = HEADER_WIDTH + PHV_WIDTH + 16;
    localparam int unsigned HALF_BASE = PHV_B_NUM * 8;
    localparam int unsigned WORD_BASE = HALF_BASE + PHV_H_NUM * 16;
    localparam logic [16:0] MAX_BYTES = 17'(HEADER_WIDTH / 8);

    if (WORD_BASE + PHV_W_NUM * 32 > PHV_WIDTH) begin : g_bad_phv
        $error("PHV_WIDTH too small for the b/h/w lane layout");
    end
    if (HEADER_WIDTH < IPV6_HDR_BITS || HEADER_WIDTH % 8 != 0) begin : g_bad_hdr
        $error("HEADER_WIDTH must be a byte multiple of at least 320 bits");
    end

    logic                           a_valid, b_in_ready, b_in_valid;
    logic [BUS_W-1:0]               a_bus, b_bus;
    logic [HEADER_WIDTH-1:0]        a_data, b_data;
    logic [PHV_WIDTH-1:0]           a_phv, b_phv;
    logic [15:0]                    a_len, b_len;
    logic                           is_ipv6, oversize, drop_fire;
    logic [16:0]                    len_sum;
    logic [7:0]                     next_hdr;
    logic [IPV6_HDR_BITS-1:0]       ipv6_hdr;
    logic [15:0]                    drop_q, drop_d, tx_q, tx_d;

    rbt_hdr_pipe_stage #(.WIDTH(BUS_W)) u_stage_a (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_proto_hdr_valid),
        .in_ready_o  (in_proto_hdr_ready),
        .in_data_i   ({in_proto_hdr_length, in_proto_hdr_phv, in_proto_hdr_data}),
        .out_valid_o (a_valid),
        .out_ready_i (b_in_ready),
        .out_data_o  (a_bus)
    );

    assign {a_len, a_phv, a_data} = a_bus;

    // Header assembly between the capture and output slices
    always_comb begin
        is_ipv6  = a_phv[WORD_BASE + PROTO_NO * 32 + TAG_IPV6];
        next_hdr = a_phv[WORD_BASE + PROTO_NO * 32 + TAG_IDP] ? NEXT_HDR_IDP : NEXT_HDR_DEFAULT;
        len_sum  = {1'b0, a_len} + {9'd0, IPV6_HDR_BYTES};
        oversize = is_ipv6 && (len_sum > MAX_BYTES);
        ipv6_hdr = {4'd6, 8'd0, 20'd0,
                    a_phv[HALF_BASE +: 16],
                    next_hdr,
                    HOP_LIMIT,
                    a_phv[WORD_BASE + SRC_IPV6_NO * 32 +: 128],
                    a_phv[WORD_BASE + DST_IP_NO * 32 +: 128]};
        b_data   = a_data;
        b_phv    = a_phv;
        b_len    = a_len;
        if (is_ipv6) begin
            b_data = {ipv6_hdr, a_data[HEADER_WIDTH-1:IPV6_HDR_BITS]};
            b_phv[SEATL_OFFSET_NO * 8 +: 8] =
                sat_sub8(a_phv[SEATL_OFFSET_NO * 8 +: 8], IPV6_HDR_BYTES);
            b_len  = len_sum[15:0];
        end
    end

    // An oversize item leaves stage A without ever entering stage B
    assign b_in_valid = a_valid && !oversize;
    assign drop_fire  = a_valid && oversize && b_in_ready;

    rbt_hdr_pipe_stage #(.WIDTH(BUS_W)) u_stage_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .in_data_i   ({b_len, b_phv, b_data}),
        .out_valid_o (out_proto_hdr_valid),
        .out_ready_i (out_proto_hdr_ready),
        .out_data_o  (b_bus)
    );

    assign {out_proto_hdr_length, out_proto_hdr_phv, out_proto_hdr_data} = b_bus;

    // Saturating drop / transmit counters
    always_comb begin
        drop_d = drop_q;
        tx_d   = tx_q;
        if (drop_fire && drop_q != '1) begin
            drop_d = drop_q + 16'd1;
        end
        if (out_proto_hdr_valid && out_proto_hdr_ready && tx_q != '1) begin
            tx_d = tx_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
            tx_q   <= '0;
        end else begin
            drop_q <= drop_d;
            tx_q   <= tx_d;
        end
    end

    assign drop_count = drop_q;
    assign tx_count   = tx_q;

endmodule

// File: tb/tb_rbt_s_ipv6_deparser.sv
// Randomized scoreboard bench for rbt_s_ipv6_deparser with a byte-level reference model.
module tb_rbt_s_ipv6_deparser;

    localparam int unsigned HW = 2048;
    localparam int unsigned PW = 408;
    localparam int unsigned WB = 88;   // word lanes start after 7 bytes + 2 halves

    typedef struct packed {
        logic [HW-1:0] data;
        logic [PW-1:0] phv;
        logic [15:0]   len;
    } item_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_len = '0;
    logic [HW-1:0] in_data = '0;
    logic [PW-1:0] in_phv = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [HW-1:0] out_data;
    logic [PW-1:0] out_phv;
    logic [15:0]   out_len;
    logic [15:0]   drop_count, tx_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned acc_count = 0;
    int unsigned exp_tx = 0;
    int unsigned exp_drop = 0;
    bit          rand_ready = 1'b0;
    item_t       cur;
    item_t       src_q[$];
    item_t       exp_q[$];
    item_t       obs_q[$];

    always #5 clk = ~clk;

    rbt_s_ipv6_deparser #(
        .HEADER_WIDTH(HW),
        .PHV_WIDTH(PW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_proto_hdr_valid   (in_valid),
        .in_proto_hdr_ready   (in_ready),
        .in_proto_hdr_length  (in_len),
        .in_proto_hdr_data    (in_data),
        .in_proto_hdr_phv     (in_phv),
        .out_proto_hdr_valid  (out_valid),
        .out_proto_hdr_ready  (out_ready),
        .out_proto_hdr_data   (out_data),
        .out_proto_hdr_phv    (out_phv),
        .out_proto_hdr_length (out_len),
        .drop_count           (drop_count),
        .tx_count             (tx_count)
    );

    // Reference: returns 0 when the item is dropped, else fills o with the expected output.
    function automatic bit model(input item_t it, output item_t o);
        logic [31:0] w [10];
        logic [7:0]  b [40];
        logic [31:0] ws, wd;
        logic [15:0] h0;
        logic [7:0]  b6;
        o = it;
        for (int k = 0; k < 10; k++) w[k] = it.phv[WB + 32*k +: 32];
        if (!w[0][4]) return 1'b1;
        if (int'(it.len) + 40 > HW / 8) return 1'b0;
        h0 = it.phv[56 +: 16];
        b[0] = 8'h60; b[1] = 8'h00; b[2] = 8'h00; b[3] = 8'h00;
        b[4] = h0[15:8]; b[5] = h0[7:0];
        b[6] = w[0][5] ? 8'h92 : 8'h11;
        b[7] = 8'd64;
        for (int i = 0; i < 16; i++) begin
            ws = w[8 - i/4];
            wd = w[4 - i/4];
            b[8 + i]  = ws[31 - 8*(i%4) -: 8];
            b[24 + i] = wd[31 - 8*(i%4) -: 8];
        end
        o.data = it.data >> 320;
        for (int i = 0; i < 40; i++) o.data[HW - 1 - 8*i -: 8] = b[i];
        b6 = it.phv[55:48];
        o.phv[55:48] = (b6 > 8'd40) ? b6 - 8'd40 : 8'd0;
        o.len = it.len + 16'd40;
        return 1'b1;
    endfunction

    function automatic item_t rand_item(input bit ipv6, input bit idp, input int unsigned max_len);
        item_t it;
        logic [415:0] p;
        for (int k = 0; k < 64; k++) it.data[32*k +: 32] = $urandom;
        for (int k = 0; k < 13; k++) p[32*k +: 32] = $urandom;
        it.phv = p[PW-1:0];
        it.phv[WB + 4] = ipv6;
        it.phv[WB + 5] = idp;
        it.len = 16'($urandom_range(0, max_len));
        return it;
    endfunction

    task automatic drive(input item_t it);
        cur      = it;
        in_valid = 1'b1;
        in_data  = it.data;
        in_phv   = it.phv;
        in_len   = it.len;
    endtask

    // One clock: called at a falling edge, samples handshakes 1 ns later, returns at the next falling edge.
    task automatic cycle();
        item_t e, o;
        bit    accepted = 1'b0;
        if (!in_valid && src_q.size() > 0) drive(src_q.pop_front());
        #1;
        if (in_valid && in_ready) begin
            accepted = 1'b1;
            acc_count++;
            if (model(cur, e)) begin
                exp_q.push_back(e);
                exp_tx++;
            end else begin
                exp_drop++;
            end
        end
        if (out_valid && out_ready) begin
            o.data = out_data; o.phv = out_phv; o.len = out_len;
            obs_q.push_back(o);
        end
        @(negedge clk);
        if (accepted) begin
            if (src_q.size() > 0) drive(src_q.pop_front());
            else in_valid = 1'b0;
        end
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int unsigned budget, output bit timed_out);
        int unsigned n = 0;
        while ((src_q.size() > 0 || in_valid || obs_q.size() < exp_q.size()) && n < budget) begin
            cycle();
            n++;
        end
        timed_out = (src_q.size() > 0 || in_valid || obs_q.size() < exp_q.size());
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || drop_count !== 16'd0 || tx_count !== 16'd0
            || out_len !== 16'd0 || out_phv !== '0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state ready=%b valid=%b drop=%0d tx=%0d len=%0d, required 1 0 0 0 0",
                     in_ready, out_valid, drop_count, tx_count, out_len);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_ipv6_basic();
        item_t it, o, e;
        bit    to;
        it = rand_item(1'b1, 1'b0, 0);
        it.phv[WB +: 32]       = 32'h10;
        it.phv[56 +: 16]       = 16'h0100;
        it.phv[WB + 32*5 +: 128] = {32'h20010db8, 32'h0, 32'h0, 32'h1};
        it.phv[WB + 32*1 +: 128] = {32'h20010db8, 32'h0, 32'h0, 32'h2};
        it.phv[55:48]          = 8'd54;
        it.len                 = 16'd100;
        src_q.push_back(it);
        cycle();
        cycle();
        vectors++;
        if (out_valid !== 1'b1 || out_data[HW-1 -: 64] !== 64'h6000000001001140
            || out_len !== 16'd140 || out_phv[55:48] !== 8'd14) begin
            miscompares++;
            $display("FAIL ipv6_latency valid=%b head=%h len=%0d b6=%0d, required 1 6000000001001140 140 14",
                     out_valid, out_data[HW-1 -: 64], out_len, out_phv[55:48]);
        end
        it.phv[WB +: 32] = 32'h30;
        src_q.push_back(it);
        cycle();
        cycle();
        vectors++;
        if (out_valid !== 1'b1 || out_data[HW-49 -: 8] !== 8'h92) begin
            miscompares++;
            $display("FAIL idp_next_hdr valid=%b nh=%h, required 1 92", out_valid, out_data[HW-49 -: 8]);
        end
        it = rand_item(1'b0, 1'b1, 200);
        it.phv[WB +: 32] = 32'h0;
        src_q.push_back(it);
        cycle();
        cycle();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== it.data || out_phv !== it.phv || out_len !== it.len) begin
            miscompares++;
            $display("FAIL passthrough head=%h len=%0d, required head=%h len=%0d",
                     out_data[HW-1 -: 64], out_len, it.data[HW-1 -: 64], it.len);
        end
        drain(50, to);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL basic_item got len=%0d head=%h, required len=%0d head=%h",
                         o.len, o.data[HW-1 -: 64], e.len, e.data[HW-1 -: 64]);
            end
        end
        vectors++;
        if (to || obs_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_count leftover obs=%0d exp=%0d timeout=%0b, required 0 0 0", obs_q.size(), exp_q.size(), to);
        end
    endtask

    task automatic test_stall();
        item_t       o, e, snap;
        bit          to, have_snap = 1'b0;
        int unsigned acc0 = acc_count;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) src_q.push_back(rand_item(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 200));
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (have_snap) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== snap.data || out_phv !== snap.phv || out_len !== snap.len) begin
                    miscompares++;
                    $display("FAIL stall_stable cycle %0d len=%0d head=%h, required len=%0d head=%h",
                             c, out_len, out_data[HW-1 -: 64], snap.len, snap.data[HW-1 -: 64]);
                end
            end else if (out_valid) begin
                snap.data = out_data; snap.phv = out_phv; snap.len = out_len;
                have_snap = 1'b1;
            end
        end
        #1;
        vectors++;
        if (acc_count - acc0 != 2 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_accepts got %0d ready=%b, required 2 0", acc_count - acc0, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b1;
        drain(50, to);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL stall_order got len=%0d head=%h, required len=%0d head=%h",
                         o.len, o.data[HW-1 -: 64], e.len, e.data[HW-1 -: 64]);
            end
        end
        vectors++;
        if (to || obs_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_count leftover obs=%0d exp=%0d timeout=%0b, required 0 0 0", obs_q.size(), exp_q.size(), to);
        end
    endtask

    task automatic test_drop_and_saturate();
        item_t       it, o, e;
        bit          to;
        int unsigned tx0 = exp_tx;
        it = rand_item(1'b1, 1'b0, 0);
        it.len = 16'd250;
        src_q.push_back(it);
        it = rand_item(1'b1, 1'b1, 0);
        it.len = 16'd216;            // exactly fills the header bus: not a drop
        it.phv[55:48] = 8'd20;
        src_q.push_back(it);
        drain(50, to);
        vectors++;
        if (drop_count !== 16'(exp_drop) || exp_drop != 1 || tx_count !== 16'(exp_tx) || exp_tx != tx0 + 1) begin
            miscompares++;
            $display("FAIL drop_counters drop=%0d tx=%0d, required drop=1 tx=%0d", drop_count, tx_count, tx0 + 1);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o !== e || o.phv[55:48] !== 8'd0 || o.len !== 16'd256) begin
                miscompares++;
                $display("FAIL sat_byte6 got b6=%0d len=%0d, required b6=0 len=256", o.phv[55:48], o.len);
            end
        end
        vectors++;
        if (to || obs_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drop_count_items leftover obs=%0d exp=%0d timeout=%0b, required 0 0 0", obs_q.size(), exp_q.size(), to);
        end
    endtask

    task automatic test_back_to_back();
        item_t       o, e;
        bit          to;
        int unsigned acc0 = acc_count;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) src_q.push_back(rand_item(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 216));
        repeat (16) cycle();
        vectors++;
        if (acc_count - acc0 != 16) begin
            miscompares++;
            $display("FAIL b2b_throughput got %0d accepts in 16 cycles, required 16", acc_count - acc0);
        end
        drain(50, to);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL b2b_item got len=%0d head=%h, required len=%0d head=%h",
                         o.len, o.data[HW-1 -: 64], e.len, e.data[HW-1 -: 64]);
            end
        end
        vectors++;
        if (to || obs_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count leftover obs=%0d exp=%0d timeout=%0b, required 0 0 0", obs_q.size(), exp_q.size(), to);
        end
    endtask

    task automatic test_random();
        item_t o, e;
        bit    to;
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) src_q.push_back(rand_item(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 260));
        drain(2000, to);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (3) cycle();
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL random_item got len=%0d phv=%h, required len=%0d phv=%h", o.len, o.phv, e.len, e.phv);
            end
        end
        vectors++;
        if (to || obs_q.size() != 0 || exp_q.size() != 0 || tx_count !== 16'(exp_tx) || drop_count !== 16'(exp_drop)) begin
            miscompares++;
            $display("FAIL random_totals obs=%0d exp=%0d tx=%0d drop=%0d, required 0 0 %0d %0d",
                     obs_q.size(), exp_q.size(), tx_count, drop_count, exp_tx, exp_drop);
        end
    endtask

    task automatic test_reset_midflight();
        item_t o, e;
        bit    to;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) src_q.push_back(rand_item(1'b1, 1'b0, 200));
        repeat (3) cycle();
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midflight_full valid=%b ready=%b, required 1 0", out_valid, in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || drop_count !== 16'd0 || tx_count !== 16'd0 || out_len !== 16'd0) begin
            miscompares++;
            $display("FAIL midflight_reset valid=%b ready=%b drop=%0d tx=%0d len=%0d, required 0 1 0 0 0",
                     out_valid, in_ready, drop_count, tx_count, out_len);
        end
        src_q.delete(); exp_q.delete(); obs_q.delete();
        in_valid = 1'b0;
        exp_tx = 0;
        exp_drop = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        src_q.push_back(rand_item(1'b1, 1'b1, 200));
        drain(50, to);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL post_reset_item got len=%0d head=%h, required len=%0d head=%h",
                         o.len, o.data[HW-1 -: 64], e.len, e.data[HW-1 -: 64]);
            end
        end
        vectors++;
        if (to || obs_q.size() != 0 || exp_q.size() != 0 || tx_count !== 16'd1) begin
            miscompares++;
            $display("FAIL post_reset_count obs=%0d exp=%0d tx=%0d, required 0 0 1", obs_q.size(), exp_q.size(), tx_count);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ipv6_basic();
        test_stall();
        test_drop_and_saturate();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
